uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an input FIFO and a valid/ready write port.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and TX/RX FSM state codes.
// Imported by the transmitter top and reusable by the matching receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, sync active-low reset, registered full/empty/count.
// Ports: push/wdata in, pop/rdata (head, combinational) out, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      count_n;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count_n = count
                 + {{AW{1'b0}}, do_push}
                 - {{AW{1'b0}}, do_pop};
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Flags are registered from the post-update count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_n;
      full  <= (count_n == DEPTH[AW:0]);
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; runtime divisor, parity, 1/2 stop bits.
// Ports: s_data/s_valid/s_ready write port, serial_out line, busy, tx_done, fifo_count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_type,
  input  logic                          two_stop,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);

  logic [2:0]           state;
  logic [2:0]           state_n;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;
  logic                 par_en;
  logic                 two_q;
  logic                 stop2;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 line_n;
  logic                 done_n;
  logic [AW:0]          count_n;

  assign s_ready = ~full;
  assign push    = s_valid && s_ready;
  assign bit_end = (baud_cnt == div_q - DIV_WIDTH'(1));
  assign count_n = fifo_count
                 + {{AW{1'b0}}, push}
                 - {{AW{1'b0}}, pop};

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (s_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    line_n  = 1'b1;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        line_n = 1'b0;
        if (bit_end) state_n = ST_DATA;
      end
      ST_DATA: begin
        line_n = shreg[0];
        if (bit_end && bit_cnt == LAST_BIT)
          state_n = par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_n = par_bit;
        if (bit_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        // Popping on the last stop cycle gives zero idle gap.
        if (bit_end && (stop2 || !two_q)) begin
          done_n = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line and tx_done are registered, so they trail the state by a cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_en     <= 1'b0;
      two_q      <= 1'b0;
      stop2      <= 1'b0;
      div_q      <= MIN_DIV;
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      serial_out <= line_n;
      tx_done    <= done_n;
      busy       <= (state_n != ST_IDLE) || (count_n != '0);
      if (pop) begin
        shreg    <= head;
        par_bit  <= (parity_type == PAR_ODD) ? ~^head : ^head;
        par_en   <= (parity_type == PAR_ODD) ||
                    (parity_type == PAR_EVEN);
        two_q    <= two_stop;
        div_q    <= (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        stop2    <= 1'b0;
      end else if (state != ST_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + DIV_WIDTH'(1);
        if (bit_end && state == ST_DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
        end
        if (bit_end && state == ST_STOP) stop2 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames,
// a line monitor pops and checks each frame cycle by cycle.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_type = 2'd0;
  logic        two_stop = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        serial_out;
  logic        busy;
  logic        tx_done;
  logic [4:0]  fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .parity_type (parity_type),
    .two_stop    (two_stop),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .serial_out  (serial_out),
    .busy        (busy),
    .tx_done     (tx_done),
    .fifo_count  (fifo_count)
  );

  typedef struct {
    logic [7:0] d;
    int         dv;
    int         pt;
    bit         tw;
  } item_t;

  item_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  bit    mon_hold = 1'b0;
  bit    in_frame = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: a falling line starts a frame; the expected waveform is
  // built from the frame rules (start, LSB-first data, parity, stops).
  initial begin : monitor
    item_t    it;
    logic     bits[$];
    int       div, len, errs, dn, ones;
    bit       bb;
    bit       want_start;
    want_start = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_hold || !rst) begin
        want_start = 1'b0;
        continue;
      end
      if (want_start) begin
        chk("b2b_start", {31'd0, serial_out}, 32'd0);
        want_start = 1'b0;
      end
      if (serial_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
          continue;
        end
        it = exp_q.pop_front();
        bb = (exp_q.size() > 0);
        div = (it.dv < 2) ? 2 : it.dv;
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(it.d[i]);
        ones = $countones(it.d);
        if (it.pt == 1) bits.push_back((ones % 2) == 0);
        if (it.pt == 2) bits.push_back((ones % 2) == 1);
        bits.push_back(1'b1);
        if (it.tw) bits.push_back(1'b1);
        len = div * bits.size();
        errs = 0;
        dn = 0;
        in_frame = 1'b1;
        for (int c = 0; c < len; c++) begin
          if (c > 0) begin
            @(negedge clk);
            if (mon_hold) break;
          end
          if (serial_out !== bits[c / div]) errs++;
          if (tx_done !== (c == len - 1)) dn++;
        end
        in_frame = 1'b0;
        if (!mon_hold) begin
          chk($sformatf("line_%02h_div%0d_p%0d_s%0d", it.d, div, it.pt,
                        it.tw ? 2 : 1), errs, 0);
          chk($sformatf("tx_done_%02h", it.d), dn, 0);
          want_start = bb;
        end
      end else if (tx_done !== 1'b0) begin
        chk("idle_tx_done", {31'd0, tx_done}, 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [7:0] d, input int dv,
                      input int pt, input bit tw);
    bit acc;
    int g;
    item_t it;
    acc = 1'b0;
    g = 0;
    s_data = d;
    s_valid = 1'b1;
    while (!acc && g < 3000) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      g++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      chk("push_timeout", 32'd0, 32'd1);
    end else begin
      it.d = d;
      it.dv = dv;
      it.pt = pt;
      it.tw = tw;
      exp_q.push_back(it);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(exp_q.size() == 0 && !in_frame && busy === 1'b0 &&
                 serial_out === 1'b1) && g < 5000);
    if (g >= 5000) chk("drain_timeout", 32'd1, 32'd0);
    cyc(3);
  endtask

  task automatic cfg(input int dv, input int pt, input bit tw);
    baud_div = dv[15:0];
    parity_type = pt[1:0];
    two_stop = tw;
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_serial_out"}, {31'd0, serial_out}, 32'd1);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_tx_done"}, {31'd0, tx_done}, 32'd0);
    chk({tag, "_fifo_count"}, {27'd0, fifo_count}, 32'd0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, dv, pt;
    bit tw;
    logic [7:0] d;

    cyc(3);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(2);

    // 8N1, div 4, 0xA5
    cfg(4, 0, 0);
    push(8'hA5, 4, 0, 0);
    @(negedge clk);
    chk("busy_after_push", {31'd0, busy}, 32'd1);
    cyc(1);
    wait_idle();

    // Parity even/odd on 0x07, div 3
    cfg(3, 2, 0);
    push(8'h07, 3, 2, 0);
    wait_idle();
    cfg(3, 1, 0);
    push(8'h07, 3, 1, 0);
    wait_idle();

    // 17 back-to-back words; FIFO fills, extra data is ignored
    cfg(4, 0, 0);
    for (int i = 0; i < 17; i++) push(8'(8'h30 + i), 4, 0, 0);
    @(negedge clk);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    chk("full_count", {27'd0, fifo_count}, 32'd16);
    s_data = 8'hEE;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("full_ignored_count", {27'd0, fifo_count}, 32'd16);
    cyc(1);
    wait_idle();

    // Two stop bits, div 5, 0x00 then 0xFF
    cfg(5, 0, 1);
    push(8'h00, 5, 0, 1);
    push(8'hFF, 5, 0, 1);
    wait_idle();

    // Reset during data bit 3 with a second word queued
    cfg(4, 0, 0);
    push(8'h3C, 4, 0, 0);
    push(8'h3D, 4, 0, 0);
    cyc(18);
    mon_hold = 1'b1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midreset");
    @(posedge clk);
    #1;
    mon_hold = 1'b0;
    cyc(2);
    push(8'h5A, 4, 0, 0);
    wait_idle();

    // Divisor change mid-frame applies to the next frame only
    cfg(4, 0, 0);
    push(8'hC3, 4, 0, 0);
    push(8'h81, 8, 0, 0);
    cyc(10);
    baud_div = 16'd8;
    wait_idle();
    cfg(0, 0, 0);
    push(8'h96, 0, 0, 0);
    wait_idle();
    cfg(1, 3, 0);
    push(8'h69, 1, 3, 0);
    wait_idle();

    // Randomized configurations and short bursts
    for (int r = 0; r < 30; r++) begin
      dv = $urandom_range(0, 6);
      pt = $urandom_range(0, 3);
      tw = 1'($urandom_range(0, 1));
      cfg(dv, pt, tw);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        push(d, dv, pt, tw);
      end
      wait_idle();
    end

    @(negedge clk);
    chk("end_fifo_count", {27'd0, fifo_count}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
